// File: rtl/sys_cont_pkg.sv
// Shared state encoding and stack-frame layout for the interrupt push sequencer.
// Defining INT_PUSH_ERRCODE_EN adds a fourth slot for the error code.
package sys_cont_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PUSH_FL,
    WAIT_FL,
    PUSH_CS,
    WAIT_CS,
    PUSH_EIP,
    WAIT_EIP,
`ifdef INT_PUSH_ERRCODE_EN
    PUSH_EC,
    WAIT_EC,
`endif
    DONE
  } push_state_e;

  localparam logic [31:0] OFS_FL  = 32'd4;
  localparam logic [31:0] OFS_CS  = 32'd8;
  localparam logic [31:0] OFS_EIP = 32'd12;
  localparam logic [31:0] OFS_EC  = 32'd16;

  localparam logic [3:0] FULL_WORD_SIZE = 4'hF;

`ifdef INT_PUSH_ERRCODE_EN
  localparam push_state_e LAST_WAIT = WAIT_EC;
  localparam logic [31:0] OFS_FINAL = OFS_EC;
`else
  localparam push_state_e LAST_WAIT = WAIT_EIP;
  localparam logic [31:0] OFS_FINAL = OFS_EIP;
`endif

  // Slot 0..3 maps to EFLAGS, CS, EIP, error code.
  function automatic logic [31:0] slot_ofs(input logic [1:0] slot);
    logic [31:0] ofs;
    case (slot)
      2'd0:    ofs = OFS_FL;
      2'd1:    ofs = OFS_CS;
      2'd2:    ofs = OFS_EIP;
      default: ofs = OFS_EC;
    endcase
    return ofs;
  endfunction

endpackage

// File: rtl/push_addr_gen.sv
// Stack address generation: slot address below the saved ESP and the
// final ESP written back once the frame is complete.
module push_addr_gen
  import sys_cont_pkg::*;
(
  input  logic [31:0] esp_i,
  input  logic [1:0]  slot_i,
  output logic [31:0] addr_o,
  output logic [31:0] final_esp_o
);

  // Plain 32-bit subtraction: the stack wraps silently.
  assign addr_o      = esp_i - slot_ofs(slot_i);
  assign final_esp_o = esp_i - OFS_FINAL;

endmodule

// File: rtl/int_push_seq.sv
// Interrupt frame push sequencer: writes EFLAGS, CS, EIP (and the error code
// when INT_PUSH_ERRCODE_EN is defined) below ESP, then reloads ESP.
module int_push_seq
  import sys_cont_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [31:0] push_eflags,
  input  logic [15:0] push_cs,
  input  logic [31:0] push_eip,
  input  logic [31:0] push_esp,
`ifdef INT_PUSH_ERRCODE_EN
  input  logic [31:0] push_errcode,
`endif
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_address,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_size,
  input  logic        mem_dp_valid,
  output logic        mem_dp_ready,
  output logic        reg_load_esp,
  output logic [31:0] reg_esp,
  output logic        push_done
);

  push_state_e state_q;
  logic [31:0] eflags_q;
  logic [15:0] cs_q;
  logic [31:0] eip_q;
  logic [31:0] esp_q;
`ifdef INT_PUSH_ERRCODE_EN
  logic [31:0] ec_q;
`endif
  logic [1:0]  slot_q;
  logic        mem_valid_q;
  logic [3:0]  mem_wr_size_q;
  logic        mem_dp_ready_q;
  logic        reg_load_esp_q;
  logic [31:0] reg_esp_q;
  logic        push_done_q;
  logic        push_ready_q;

  logic [31:0] slot_addr;
  logic [31:0] final_esp;
  logic [31:0] slot_data;

  push_addr_gen u_addr (
    .esp_i       (esp_q),
    .slot_i      (slot_q),
    .addr_o      (slot_addr),
    .final_esp_o (final_esp)
  );

  always_comb begin
    slot_data = '0;
    case (slot_q)
      2'd0:    slot_data = eflags_q;
      2'd1:    slot_data = {16'h0, cs_q};
      2'd2:    slot_data = eip_q;
`ifdef INT_PUSH_ERRCODE_EN
      default: slot_data = ec_q;
`else
      default: slot_data = '0;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      eflags_q       <= '0;
      cs_q           <= '0;
      eip_q          <= '0;
      esp_q          <= '0;
`ifdef INT_PUSH_ERRCODE_EN
      ec_q           <= '0;
`endif
      slot_q         <= '0;
      mem_valid_q    <= 1'b0;
      mem_wr_size_q  <= '0;
      mem_dp_ready_q <= 1'b0;
      reg_load_esp_q <= 1'b0;
      reg_esp_q      <= '0;
      push_done_q    <= 1'b0;
      push_ready_q   <= 1'b1;
    end else begin
      push_done_q    <= 1'b0;
      reg_load_esp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (push_valid) begin
            eflags_q      <= push_eflags;
            cs_q          <= push_cs;
            eip_q         <= push_eip;
            esp_q         <= push_esp;
`ifdef INT_PUSH_ERRCODE_EN
            ec_q          <= push_errcode;
`endif
            slot_q        <= 2'd0;
            mem_valid_q   <= 1'b1;
            mem_wr_size_q <= FULL_WORD_SIZE;
            push_ready_q  <= 1'b0;
            state_q       <= PUSH_FL;
          end
        end
        PUSH_FL,
        PUSH_CS,
`ifdef INT_PUSH_ERRCODE_EN
        PUSH_EC,
`endif
        PUSH_EIP: begin
          // A completion in the same cycle is left for the WAIT state.
          if (mem_ready) begin
            mem_valid_q    <= 1'b0;
            mem_wr_size_q  <= '0;
            mem_dp_ready_q <= 1'b1;
            state_q        <= push_state_e'(state_q + 4'd1);
          end
        end
        WAIT_FL,
        WAIT_CS,
`ifdef INT_PUSH_ERRCODE_EN
        WAIT_EC,
`endif
        WAIT_EIP: begin
          if (mem_dp_valid) begin
            mem_dp_ready_q <= 1'b0;
            if (state_q == LAST_WAIT) begin
              push_done_q    <= 1'b1;
              reg_load_esp_q <= 1'b1;
              reg_esp_q      <= final_esp;
              state_q        <= DONE;
            end else begin
              slot_q        <= slot_q + 2'd1;
              mem_valid_q   <= 1'b1;
              mem_wr_size_q <= FULL_WORD_SIZE;
              state_q       <= push_state_e'(state_q + 4'd1);
            end
          end
        end
        DONE: begin
          push_ready_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          push_ready_q <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign push_ready   = push_ready_q;
  assign mem_valid    = mem_valid_q;
  assign mem_wr_en    = mem_valid_q;
  assign mem_wr_size  = mem_wr_size_q;
  assign mem_address  = mem_valid_q ? slot_addr : '0;
  assign mem_wr_data  = mem_valid_q ? slot_data : '0;
  assign mem_dp_ready = mem_dp_ready_q;
  assign reg_load_esp = reg_load_esp_q;
  assign reg_esp      = reg_esp_q;
  assign push_done    = push_done_q;

endmodule

// File: tb/tb_int_push_seq.sv
// Directed bench for int_push_seq; builds with or without INT_PUSH_ERRCODE_EN.
module tb_int_push_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_eflags;
  logic [15:0] push_cs;
  logic [31:0] push_eip;
  logic [31:0] push_esp;
  logic [31:0] push_errcode;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_size;
  logic        mem_dp_valid;
  logic        mem_dp_ready;
  logic        reg_load_esp;
  logic [31:0] reg_esp;
  logic        push_done;

`ifdef INT_PUSH_ERRCODE_EN
  localparam int NW  = 4;
  localparam int LAT = 9;
`else
  localparam int NW  = 3;
  localparam int LAT = 7;
`endif

  int_push_seq dut (
    .clk          (clk),
    .reset        (reset),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .push_eflags  (push_eflags),
    .push_cs      (push_cs),
    .push_eip     (push_eip),
    .push_esp     (push_esp),
`ifdef INT_PUSH_ERRCODE_EN
    .push_errcode (push_errcode),
`endif
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_address  (mem_address),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_size  (mem_wr_size),
    .mem_dp_valid (mem_dp_valid),
    .mem_dp_ready (mem_dp_ready),
    .reg_load_esp (reg_load_esp),
    .reg_esp      (reg_esp),
    .push_done    (push_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bad_wr = 0;
  int ld_mis = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] resp_q[$];
  int acc_q[$];
  int done_q[$];

  // Edge monitor: records accepted requests, write handshakes and completions.
  always @(posedge clk) begin
    if (push_valid && push_ready && !reset) acc_q.push_back(cyc);
    if (mem_valid && mem_ready) begin
      wa.push_back(mem_address);
      wd.push_back(mem_wr_data);
      if (!(mem_wr_en === 1'b1 && mem_wr_size === 4'hF)) bad_wr++;
    end
    if (push_done === 1'b1) begin
      done_q.push_back(cyc);
      resp_q.push_back(reg_esp);
    end
    if (push_done !== reg_load_esp) ld_mis++;
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    return (i < wa.size()) ? wa[i] : 32'hBAD0BAD0;
  endfunction

  function automatic logic [31:0] qd(input int i);
    return (i < wd.size()) ? wd[i] : 32'hBAD0BAD0;
  endfunction

  function automatic logic [31:0] qr(input int i);
    return (i < resp_q.size()) ? resp_q[i] : 32'hBAD0BAD0;
  endfunction

  function automatic int qacc(input int i);
    return (i < acc_q.size()) ? acc_q[i] : -1000;
  endfunction

  function automatic int qdone(input int i);
    return (i < done_q.size()) ? done_q[i] : 1000;
  endfunction

  task automatic clr();
    wa.delete();
    wd.delete();
    resp_q.delete();
    acc_q.delete();
    done_q.delete();
  endtask

  task automatic set_in(input logic [31:0] fl, input logic [15:0] cs,
                        input logic [31:0] eip, input logic [31:0] esp,
                        input logic [31:0] ec);
    push_eflags  = fl;
    push_cs      = cs;
    push_eip     = eip;
    push_esp     = esp;
    push_errcode = ec;
  endtask

  // One-cycle request; returns 1ns after the accepting edge.
  task automatic start();
    push_valid = 1'b1;
    @(posedge clk);
    #1 push_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_q.size() < n && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("done_count", 32'(done_q.size()), 32'(n));
  endtask

  logic [31:0] ea[4];
  logic [31:0] ed[4];

  initial begin
    reset = 1'b1;
    push_valid = 1'b0;
    mem_ready = 1'b1;
    mem_dp_valid = 1'b1;
    set_in(32'h0, 16'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_push_ready", {31'b0, push_ready}, 32'd1);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
    chk("rst_dp_ready", {31'b0, mem_dp_ready}, 32'd0);
    chk("rst_load_esp", {31'b0, reg_load_esp}, 32'd0);
    chk("rst_push_done", {31'b0, push_done}, 32'd0);
    chk("rst_address", mem_address, 32'h0);
    chk("rst_wr_data", mem_wr_data, 32'h0);
    chk("rst_wr_size", {28'b0, mem_wr_size}, 32'h0);
    chk("rst_reg_esp", reg_esp, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic frame, all acknowledgements immediate.
    clr();
    set_in(32'h202, 16'h8, 32'h4010, 32'h1000, 32'hE);
    start();
    wait_done(1);
    ea = '{32'hFFC, 32'hFF8, 32'hFF4, 32'hFF0};
    ed = '{32'h202, 32'h8, 32'h4010, 32'hE};
    chk("t1_nwrites", 32'(wa.size()), 32'(NW));
    for (int i = 0; i < NW; i++) begin
      chk("t1_addr", qa(i), ea[i]);
      chk("t1_data", qd(i), ed[i]);
    end
`ifdef INT_PUSH_ERRCODE_EN
    chk("t1_reg_esp", qr(0), 32'hFF0);
`else
    chk("t1_reg_esp", qr(0), 32'hFF4);
`endif
    // Accept cycle plus LAT more: eight cycles inclusive without errcode.
    chk("t1_latency", 32'(qdone(0) - qacc(0)), 32'(LAT));
    @(negedge clk);
    chk("t1_ready_again", {31'b0, push_ready}, 32'd1);

    // mem_ready held low for 5 cycles while CS is being offered.
    clr();
    start();
    @(posedge clk);
    @(posedge clk);
    #1 mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_addr", mem_address, 32'hFF8);
      chk("t2_stall_data", mem_wr_data, 32'h8);
      chk("t2_stall_valid", {31'b0, mem_valid}, 32'd1);
      @(posedge clk);
    end
    #1;
    chk("t2_no_advance", 32'(wa.size()), 32'd1);
    chk("t2_dp_ready_low", {31'b0, mem_dp_ready}, 32'd0);
    mem_ready = 1'b1;
    wait_done(1);
    chk("t2_nwrites", 32'(wa.size()), 32'(NW));
    chk("t2_cs_addr", qa(1), 32'hFF8);

    // Stack wrap below zero.
    clr();
    set_in(32'h46, 16'h10, 32'h1234, 32'h8, 32'h77);
    start();
    wait_done(1);
    ea = '{32'h4, 32'h0, 32'hFFFFFFFC, 32'hFFFFFFF8};
    for (int i = 0; i < NW; i++) chk("t3_addr", qa(i), ea[i]);
`ifdef INT_PUSH_ERRCODE_EN
    chk("t3_reg_esp", qr(0), 32'hFFFFFFF8);
`else
    chk("t3_reg_esp", qr(0), 32'hFFFFFFFC);
`endif

    // Reset while waiting for the EIP completion.
    clr();
    set_in(32'h2, 16'h18, 32'h8000, 32'h5000, 32'h1);
    start();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_in_wait_eip", {31'b0, mem_dp_ready}, 32'd1);
    chk("t4_writes_before", 32'(wa.size()), 32'd3);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t4_push_ready", {31'b0, push_ready}, 32'd1);
    chk("t4_push_done", {31'b0, push_done}, 32'd0);
    chk("t4_load_esp", {31'b0, reg_load_esp}, 32'd0);
    chk("t4_mem_valid", {31'b0, mem_valid}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("t4_no_done", 32'(done_q.size()), 32'd0);
    chk("t4_no_more_writes", 32'(wa.size()), 32'd3);

    // Request held high, inputs change mid-frame; back-to-back frame.
    clr();
    set_in(32'hA1, 16'h23, 32'hA3, 32'h2000, 32'hA5);
    push_valid = 1'b1;
    @(posedge clk);
    #1 set_in(32'hB1, 16'h2B, 32'hB3, 32'h3000, 32'hB5);
    wait_done(1);
    @(posedge clk);
    #1 push_valid = 1'b0;
    chk("t5_second_accept", 32'(acc_q.size()), 32'd2);
    chk("t5_accept_after_done", 32'(qacc(1) - qdone(0)), 32'd1);
    ed = '{32'hA1, 32'h23, 32'hA3, 32'hA5};
    for (int i = 0; i < NW; i++) chk("t5_snap_data", qd(i), ed[i]);
    chk("t5_snap_addr", qa(0), 32'h1FFC);
    wait_done(2);
    ed = '{32'hB1, 32'h2B, 32'hB3, 32'hB5};
    for (int i = 0; i < NW; i++) chk("t5_f2_data", qd(NW + i), ed[i]);
    chk("t5_f2_addr", qa(NW), 32'h2FFC);
`ifdef INT_PUSH_ERRCODE_EN
    chk("t5_f2_reg_esp", qr(1), 32'h2FF0);
`else
    chk("t5_f2_reg_esp", qr(1), 32'h2FF4);
`endif

    chk("write_attrs", 32'(bad_wr), 32'd0);
    chk("load_esp_vs_done", 32'(ld_mis), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_push_seq.md
INT_PUSH_SEQ -- requirements
Module: int_push_seq

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: push_valid  in  1  request to push an interrupt frame.
REQ-004 SHALL have port: push_ready  out  1  high only in IDLE, meaning a request is accepted.
REQ-005 SHALL have port: push_eflags  in  32  EFLAGS value to save.
REQ-006 SHALL have port: push_cs  in  16  CS value to save.
REQ-007 SHALL have port: push_eip  in  32  return EIP to save.
REQ-008 SHALL have port: push_esp  in  32  current ESP.
REQ-009 SHALL have port: mem_valid  out  1  write request valid.
REQ-010 SHALL have port: mem_ready  in  1  write request accepted.
REQ-011 SHALL have ports: mem_address  out  32 | mem_wr_en  out  1 | mem_wr_data  out  32 | mem_wr_size  out  4.
REQ-012 SHALL have ports: mem_dp_valid  in  1  write completion | mem_dp_ready  out  1  completion accepted.
REQ-013 SHALL have ports: reg_load_esp  out  1 | reg_esp  out  32  final ESP writeback.
REQ-014 SHALL have port: push_done  out  1  one-cycle pulse when the frame is complete.

Function
REQ-015 SHALL snapshot eflags/cs/eip/esp into internal registers when push_valid && push_ready; later input changes have no effect.
REQ-016 SHALL push in the order EFLAGS, CS, EIP, the inverse of the iretd pop order EIP, CS, EFLAGS.
REQ-017 SHALL use states IDLE, PUSH_FL, WAIT_FL, PUSH_CS, WAIT_CS, PUSH_EIP, WAIT_EIP, DONE.
REQ-018 SHALL transition IDLE->PUSH_FL on accept, PUSH_x->WAIT_x on mem_ready, WAIT_x->next PUSH (or DONE) on mem_dp_valid, and DONE->IDLE unconditionally.
REQ-019 SHALL, in PUSH_x, assert mem_valid=1, mem_wr_en=1 and mem_wr_size=4'hF, holding address and data stable until mem_ready.
REQ-020 SHALL assert mem_dp_ready=1 only in WAIT_x; mem_dp_valid outside WAIT_x SHALL be ignored.
REQ-021 SHALL use the addresses EFLAGS at esp-4, CS at esp-8 (data {16'h0,cs}), and EIP at esp-12, all modulo 2^32 (wrap, no fault).
REQ-022 SHALL, in DONE, pulse push_done=1 and reg_load_esp=1 with reg_esp = esp-12 (esp-16 with errcode); both outputs SHALL be 0 otherwise.
REQ-023 SHALL treat mem_ready and mem_dp_valid arriving in the same cycle in PUSH_x as acceptance only; completion is counted in the following WAIT_x.
REQ-024 SHALL ignore push_valid while not in IDLE; a request in the DONE cycle SHALL be accepted on the next cycle.
REQ-025 SHALL take minimum latency 8 cycles from accept to push_done, with mem_ready and mem_dp_valid tied high.

Reset
REQ-026 SHALL, on reset, set state=IDLE, all snapshot registers=0, and mem_valid/mem_wr_en/mem_dp_ready/reg_load_esp/push_done=0, push_ready=1, mem_address/mem_wr_data/reg_esp=0, mem_wr_size=0.
REQ-027 SHALL, on reset mid-frame, abandon the frame with no ESP load and no push_done.

Configuration
REQ-028 SHALL, with INT_PUSH_ERRCODE_EN defined, add input push_errcode (32), add states PUSH_EC/WAIT_EC after WAIT_EIP, push the error code at esp-16, and load final ESP=esp-16.
REQ-029 SHALL, without INT_PUSH_ERRCODE_EN, have no push_errcode port and use three pushes only.

Structure
REQ-030 SHALL place the state encoding, frame offsets (4/8/12/16) and FULL_WORD_SIZE=4'hF in shared package sys_cont_pkg.
REQ-031 SHALL implement address computation as sub-module push_addr_gen (esp snapshot, slot index -> address, final ESP).

Verification
REQ-032 SHALL cover: esp=32'h1000, eflags=32'h202, cs=16'h8, eip=32'h4010, all acks immediate -> writes 0xFFC=0x202, 0xFF8=0x8, 0xFF4=0x4010; reg_esp=0xFF4; push_done 8 cycles after accept.
REQ-033 SHALL cover: mem_ready held low 5 cycles in PUSH_CS -> mem_address=0xFF8 and mem_wr_data=0x8 stable throughout; no advance.
REQ-034 SHALL cover: esp=32'h8 -> addresses 0x4, 0x0, 0xFFFFFFFC; reg_esp=0xFFFFFFFC.
REQ-035 SHALL cover: reset asserted in WAIT_EIP -> next cycle IDLE, push_ready=1, no reg_load_esp or push_done pulse.
REQ-036 SHALL cover: push_valid held high through a frame with inputs changed mid-frame -> written data equals the snapshot; second frame accepted the cycle after DONE.
REQ-037 SHALL cover: with INT_PUSH_ERRCODE_EN and errcode=32'hE, esp=32'h1000 -> 4th write 0xFF0=0xE; reg_esp=0xFF0.
